// File: rtl/stateful_processor_sequencer_pkg.sv
// Shared types and constants for the byte-stream processor sequencer.
package stateful_processor_sequencer_pkg;

  // Width of one input byte lane.
  localparam int unsigned ByteW = 8;

  // Latency counter width; covers PROC_LATENCY up to 15.
  localparam int unsigned LatW = 4;

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StFire    = 2'd1,
    StWait    = 2'd2,
    StEmit    = 2'd3
  } seq_state_e;

  // Byte index width; at least one bit even when a word is a single byte.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stateful_processor_sequencer_byte_word_packer.sv
// Packs consecutive bytes into a word, LSB first, and pulses when the last byte lands.
module stateful_processor_sequencer_byte_word_packer
  import stateful_processor_sequencer_pkg::*;
#(
  parameter int unsigned REPLICATION_FACTOR = 3
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_valid,
  input  logic [ByteW-1:0]                    i_byte,
  output logic [ByteW*REPLICATION_FACTOR-1:0] o_word,
  output logic                                o_word_complete,
  output logic                                o_partial
);

  localparam int unsigned IdxW = idx_width(REPLICATION_FACTOR);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(REPLICATION_FACTOR - 1);

  logic [IdxW-1:0]                    r_byte_idx;
  logic [IdxW-1:0]                    w_byte_idx_d;
  logic [ByteW*REPLICATION_FACTOR-1:0] r_pack;
  logic [ByteW*REPLICATION_FACTOR-1:0] w_pack_d;

  // Next byte index and pack contents for an accepted byte.
  always_comb begin
    w_byte_idx_d    = r_byte_idx;
    w_pack_d        = r_pack;
    o_word_complete = i_valid && (r_byte_idx == LastIdx);
    if (i_valid) begin
      for (int unsigned k = 0; k < REPLICATION_FACTOR; k++) begin
        if (r_byte_idx == IdxW'(k)) begin
          w_pack_d[k*ByteW +: ByteW] = i_byte;
        end
      end
      w_byte_idx_d = o_word_complete ? '0 : r_byte_idx + IdxW'(1);
    end
  end

  // Byte index and pack register; a partial word is discarded on reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_byte_idx <= '0;
      r_pack     <= '0;
    end else begin
      r_byte_idx <= w_byte_idx_d;
      r_pack     <= w_pack_d;
    end
  end

  assign o_word    = r_pack;
  assign o_partial = (r_byte_idx != '0);

endmodule

// File: rtl/stateful_processor_sequencer.sv
// Sequences a stateful processor from a byte stream: pack a word, fire one enable,
// wait the processor latency, capture the result and offer it on valid/ready.
module stateful_processor_sequencer
  import stateful_processor_sequencer_pkg::*;
#(
  parameter int unsigned REPLICATION_FACTOR = 3,   // >= 1
  parameter int unsigned PROC_LATENCY       = 1,   // 0..15, 0 = combinational processor
  parameter int unsigned COUNT_WIDTH        = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ByteW-1:0]                    in_data,
  output logic                                proc_enable,
  output logic [ByteW*REPLICATION_FACTOR-1:0] proc_data_in,
  input  logic [ByteW-1:0]                    proc_data_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ByteW-1:0]                    out_data,
  output logic                                busy,
  output logic [COUNT_WIDTH-1:0]              words_done
);

  seq_state_e             r_state;
  seq_state_e             w_state_d;
  logic [LatW-1:0]        r_lat_cnt;
  logic [LatW-1:0]        w_lat_cnt_d;
  logic                   w_capture;
  logic [ByteW-1:0]       r_out_data;
  logic [COUNT_WIDTH-1:0] r_words_done;
  logic                   w_in_xfer;
  logic                   w_out_xfer;
  logic                   w_word_complete;
  logic                   w_partial;
  logic [ByteW*REPLICATION_FACTOR-1:0] w_word;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = (r_state == StEmit) && out_ready;

  stateful_processor_sequencer_byte_word_packer #(
    .REPLICATION_FACTOR (REPLICATION_FACTOR)
  ) u_packer (
    .i_clk           (clock),
    .i_rst_n         (reset),
    .i_valid         (w_in_xfer),
    .i_byte          (in_data),
    .o_word          (w_word),
    .o_word_complete (w_word_complete),
    .o_partial       (w_partial)
  );

  // Next-state, latency countdown and result-capture strobe.
  always_comb begin
    w_state_d   = r_state;
    w_lat_cnt_d = r_lat_cnt;
    w_capture   = 1'b0;
    unique case (r_state)
      StCollect: begin
        if (w_word_complete) w_state_d = StFire;
      end
      StFire: begin
        if (PROC_LATENCY == 0) begin
          w_capture = 1'b1;
          w_state_d = StEmit;
        end else begin
          w_lat_cnt_d = LatW'(PROC_LATENCY - 1);
          w_state_d   = StWait;
        end
      end
      StWait: begin
        if (r_lat_cnt == '0) begin
          w_capture = 1'b1;
          w_state_d = StEmit;
        end else begin
          w_lat_cnt_d = r_lat_cnt - LatW'(1);
        end
      end
      StEmit: begin
        if (out_ready) w_state_d = StCollect;
      end
      default: w_state_d = StCollect;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= StCollect;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_lat_cnt <= w_lat_cnt_d;
    end
  end

  // Result capture; held stable throughout EMIT.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_out_data <= '0;
    end else if (w_capture) begin
      r_out_data <= proc_data_out;
    end
  end

  // Accepted-result counter, wraps silently.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_words_done <= '0;
    end else if (w_out_xfer) begin
      r_words_done <= r_words_done + COUNT_WIDTH'(1);
    end
  end

  // The processor shares this reset, so a FIRE cycle coinciding with reset must not
  // advance its state.
  assign proc_enable  = (r_state == StFire) && reset;
  assign in_ready     = (r_state == StCollect);
  assign out_valid    = (r_state == StEmit);
  assign out_data     = r_out_data;
  assign proc_data_in = w_word;
  assign words_done   = r_words_done;
  assign busy         = (r_state != StCollect) || w_partial;

endmodule

// File: tb/tb_stateful_processor_sequencer.sv
// Bench: DUT A uses default parameters, DUT B uses one-byte words, a combinational
// processor and a 2-bit word counter. Both drive accumulator processor stubs.
module tb_stateful_processor_sequencer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // DUT A signals
  logic        a_in_valid, a_in_ready, a_proc_enable, a_out_valid, a_out_ready, a_busy;
  logic [7:0]  a_in_data, a_proc_data_out, a_out_data;
  logic [23:0] a_proc_data_in;
  logic [15:0] a_words_done;
  // DUT B signals
  logic        b_in_valid, b_in_ready, b_proc_enable, b_out_valid, b_out_ready, b_busy;
  logic [7:0]  b_in_data, b_proc_data_out, b_out_data, b_proc_data_in;
  logic [1:0]  b_words_done;

  stateful_processor_sequencer dut_a (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (a_in_valid),
    .in_ready      (a_in_ready),
    .in_data       (a_in_data),
    .proc_enable   (a_proc_enable),
    .proc_data_in  (a_proc_data_in),
    .proc_data_out (a_proc_data_out),
    .out_valid     (a_out_valid),
    .out_ready     (a_out_ready),
    .out_data      (a_out_data),
    .busy          (a_busy),
    .words_done    (a_words_done)
  );

  stateful_processor_sequencer #(
    .REPLICATION_FACTOR (1),
    .PROC_LATENCY       (0),
    .COUNT_WIDTH        (2)
  ) dut_b (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (b_in_valid),
    .in_ready      (b_in_ready),
    .in_data       (b_in_data),
    .proc_enable   (b_proc_enable),
    .proc_data_in  (b_proc_data_in),
    .proc_data_out (b_proc_data_out),
    .out_valid     (b_out_valid),
    .out_ready     (b_out_ready),
    .out_data      (b_out_data),
    .busy          (b_busy),
    .words_done    (b_words_done)
  );

  // Processor stubs: running byte-sum accumulators, A registered, B combinational.
  logic [7:0] a_acc, b_acc;
  always @(posedge clock) begin
    if (!reset) a_acc <= 8'h00;
    else if (a_proc_enable)
      a_acc <= a_acc + a_proc_data_in[7:0] + a_proc_data_in[15:8] + a_proc_data_in[23:16];
  end
  assign a_proc_data_out = a_acc;

  always @(posedge clock) begin
    if (!reset) b_acc <= 8'h00;
    else if (b_proc_enable) b_acc <= b_proc_data_out;
  end
  assign b_proc_data_out = b_acc + b_proc_data_in;

  // Reference model state
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  a_model_acc;
  int          a_model_done;
  int          a_en_cnt = 0;
  logic [23:0] a_exp_pdi[$];
  logic [7:0]  b_model_acc;
  int          b_model_done;
  int          b_en_cnt = 0;
  logic [7:0]  b_exp_pdi[$];
  logic [7:0]  b_exp_res[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: every enable must match a queued word; B results checked at handshake.
  initial forever begin
    @(negedge clock);
    if (a_proc_enable) begin
      a_en_cnt++;
      check_eq("a_en_pending", a_exp_pdi.size() != 0, 1);
      if (a_exp_pdi.size() != 0) check_eq("a_proc_data_in", a_proc_data_in, a_exp_pdi.pop_front());
    end
    if (b_proc_enable) begin
      b_en_cnt++;
      check_eq("b_en_pending", b_exp_pdi.size() != 0, 1);
      if (b_exp_pdi.size() != 0) check_eq("b_proc_data_in", b_proc_data_in, b_exp_pdi.pop_front());
    end
    if (reset && b_out_valid && b_out_ready) begin
      check_eq("b_words_done_pre", b_words_done, b_model_done % 4);
      check_eq("b_res_pending", b_exp_res.size() != 0, 1);
      if (b_exp_res.size() != 0) check_eq("b_out_data", b_out_data, b_exp_res.pop_front());
      b_model_done++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 with reset released.
  task automatic do_reset();
    reset = 1'b0;
    a_model_acc = 8'h00; a_model_done = 0; a_exp_pdi.delete();
    b_model_acc = 8'h00; b_model_done = 0; b_exp_pdi.delete(); b_exp_res.delete();
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic a_send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin @(posedge clock); #1; end
    a_in_valid = 1'b1;
    a_in_data  = b;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock);
      ok = a_in_ready;
      @(posedge clock); #1;
    end
    check_eq("a_accept", ok, 1);
    a_in_valid = 1'b0;
    a_in_data  = 8'($urandom);
  endtask

  task automatic a_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input int g1, input int g2, input int stall);
    int unsigned t0;
    int en0;
    en0 = a_en_cnt;
    a_model_acc = a_model_acc + b0 + b1 + b2;
    a_exp_pdi.push_back({b2, b1, b0});
    a_out_ready = (stall == 0);
    a_send_byte(b0, 0);
    check_eq("a_busy_mid", a_busy, 1);
    a_send_byte(b1, g1);
    a_send_byte(b2, g2);
    check_eq("a_no_early_en", a_en_cnt, en0);
    t0 = cyc;
    for (int n = 0; n < 20 && !a_out_valid; n++) @(negedge clock);
    check_eq("a_out_valid_seen", a_out_valid, 1);
    check_eq("a_latency", cyc - t0, 2);
    check_eq("a_out_data", a_out_data, a_model_acc);
    check_eq("a_en_once", a_en_cnt - en0, 1);
    for (int i = 0; i < stall; i++) begin
      check_eq("a_hold_valid", a_out_valid, 1);
      check_eq("a_hold_data", a_out_data, a_model_acc);
      check_eq("a_hold_in_ready", a_in_ready, 0);
      @(negedge clock);
    end
    if (stall > 0) begin
      @(posedge clock); #1;
      a_out_ready = 1'b1;
      @(negedge clock);
      check_eq("a_valid_before_xfer", a_out_valid, 1);
    end
    @(posedge clock); #1;
    a_model_done++;
    check_eq("a_words_done", a_words_done, a_model_done & 32'hFFFF);
    check_eq("a_out_valid_drop", a_out_valid, 0);
    check_eq("a_in_ready_back", a_in_ready, 1);
    check_eq("a_en_per_word", a_en_cnt - en0, 1);
    a_out_ready = 1'b1;
  endtask

  task automatic b_send(input logic [7:0] b, input bit rnd_ready, output int unsigned t_acc);
    bit ok;
    b_model_acc = b_model_acc + b;
    b_exp_pdi.push_back(b);
    b_exp_res.push_back(b_model_acc);
    b_in_valid = 1'b1;
    b_in_data  = b;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (rnd_ready) b_out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      ok = b_in_ready;
      @(posedge clock); #1;
    end
    check_eq("b_accept", ok, 1);
    t_acc = cyc;
  endtask

  task automatic b_drain();
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    for (int n = 0; n < 50 && b_exp_res.size() != 0; n++) begin @(posedge clock); #1; end
    check_eq("b_drained", b_exp_res.size(), 0);
  endtask

  initial begin
    int unsigned t, t_prev;
    int en0;
    reset = 1'b0;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
    a_model_acc = 8'h00; a_model_done = 0; b_model_acc = 8'h00; b_model_done = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    // Reset state
    check_eq("rst_a_in_ready", a_in_ready, 1);
    check_eq("rst_a_out_valid", a_out_valid, 0);
    check_eq("rst_a_out_data", a_out_data, 0);
    check_eq("rst_a_words_done", a_words_done, 0);
    check_eq("rst_a_busy", a_busy, 0);
    check_eq("rst_a_proc_enable", a_proc_enable, 0);
    check_eq("rst_a_proc_data_in", a_proc_data_in, 0);
    check_eq("rst_b_in_ready", b_in_ready, 1);
    check_eq("rst_b_words_done", b_words_done, 0);

    // Basic word
    a_word(8'h11, 8'h22, 8'h33, 0, 0, 0);
    check_eq("basic_result", a_out_data, 8'h66);

    // Stateful chain from a cleared accumulator
    do_reset();
    en0 = a_en_cnt;
    a_word(8'h01, 8'h02, 8'h03, 0, 0, 0);
    check_eq("chain_first", a_out_data, 8'h06);
    a_word(8'h10, 8'h10, 8'h10, 0, 0, 0);
    check_eq("chain_second", a_out_data, 8'h36);
    check_eq("chain_enables", a_en_cnt - en0, 2);

    // Back-pressure for 10 cycles
    a_word(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 10);

    // Input gaps: valid pattern 1,0,0,1,0,1
    a_word(8'hA5, 8'h5A, 8'hC3, 2, 1, 0);

    // Reset mid-word
    en0 = a_en_cnt;
    a_send_byte(8'hAA, 0);
    a_send_byte(8'hBB, 0);
    check_eq("midrst_busy_before", a_busy, 1);
    do_reset();
    check_eq("midrst_busy_after", a_busy, 0);
    check_eq("midrst_in_ready", a_in_ready, 1);
    check_eq("midrst_words_done", a_words_done, 0);
    check_eq("midrst_no_enable", a_en_cnt, en0);
    a_word(8'hFF, 8'h01, 8'h00, 0, 0, 0);
    check_eq("midrst_result", a_out_data, 8'h00);
    check_eq("midrst_enables", a_en_cnt - en0, 1);

    // Randomized words with random gaps and stalls
    for (int i = 0; i < 20; i++) begin
      a_word(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
    end
    check_eq("a_queue_empty", a_exp_pdi.size(), 0);

    // DUT B: single-byte words, combinational processor, 2-bit counter wrap
    do_reset();
    en0 = b_en_cnt;
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      b_send(8'($urandom), 1'b0, t);
      if (i > 0) check_eq("b_period", t - t_prev, 3);
      t_prev = t;
    end
    b_drain();
    check_eq("b_wrap_final", b_words_done, 2'd1);
    check_eq("b_enables", b_en_cnt - en0, 5);

    // DUT B: random downstream back-pressure
    for (int i = 0; i < 12; i++) b_send(8'($urandom), 1'b1, t);
    b_drain();
    check_eq("b_done_total", b_words_done, 2'(b_model_done));
    check_eq("b_queue_empty", b_exp_pdi.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
